// File: rtl/cube_calc.sv
// Iterative unsigned cuber: y = x^3 by two back-to-back shift-add multiplies
// (x*x, then x*sq). Start/busy/done handshake; result held until the next done.
module cube_calc #(
  parameter int W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     x_in,
  output logic             busy,
  output logic             done,
  output logic [3*W-1:0]   cube_out,
  output logic             ovf32
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CU   = 2'd2,
    DONE = 2'd3
  } state_t;

  // True when any bit at or above 2^32 is set; constant 0 when 3W <= 32.
  function automatic logic above_32(input logic [3*W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 32; i < 3 * W; i++) begin
      r = r | v[i];
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    xr_q, xr_d;
  logic [2*W-1:0]  sq_q, sq_d;
  logic [3*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3*W-1:0]  cube_q, cube_d;
  logic            ovf_q, ovf_d;

  logic [3*W-1:0]  xr_ext_s;
  logic [3*W-1:0]  sq_ext_s;
  logic [3*W-1:0]  sum_s;

  assign xr_ext_s = {{(2*W){1'b0}}, xr_q};
  assign sq_ext_s = {{W{1'b0}}, sq_q};

  // Next-state and datapath: one partial product per cycle in SQ and CU.
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    sq_d    = sq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cube_d  = cube_q;
    ovf_d   = ovf_q;
    sum_s   = acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          xr_d    = x_in;
          acc_d   = {(3*W){1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = SQ;
        end else begin
          state_d = IDLE;
        end
      end
      SQ: begin
        if (xr_q[cnt_q]) begin
          sum_s = acc_q + (xr_ext_s << cnt_q);
        end else begin
          sum_s = acc_q;
        end
        // The last partial product must land in sq, so latch the sum, not acc_q.
        if (cnt_q == CNT_LAST) begin
          sq_d    = sum_s[2*W-1:0];
          acc_d   = {(3*W){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = CU;
        end else begin
          acc_d   = sum_s;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      CU: begin
        if (xr_q[cnt_q]) begin
          sum_s = acc_q + (sq_ext_s << cnt_q);
        end else begin
          sum_s = acc_q;
        end
        acc_d = sum_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        cube_d  = acc_q;
        ovf_d   = above_32(acc_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xr_q    <= {W{1'b0}};
      sq_q    <= {(2*W){1'b0}};
      acc_q   <= {(3*W){1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cube_q  <= {(3*W){1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      sq_q    <= sq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cube_q  <= cube_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cube_out = cube_q;
  assign ovf32    = ovf_q;

endmodule

// File: doc/cube_calc.md
Name: cube_calc

Overview:
- Iterative integer cuber that computes y = x^3 using two sequential shift-add multiplications.
- It is the forward, inverse-direction counterpart to the team's digit-by-digit cube-root unit. Its main uses are regenerating the radicand from a computed root and round-trip checking of root results.
- Uses a start/busy/done handshake and holds the result until the next completed operation.

Parameters:
- W, 11, operand width in bits. The result width is 3*W. The default covers every cube root of a 32-bit value (max root 1625).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x_in  input  W  operand; captured on the edge where start is accepted.
- busy  output  1  high from the accept edge until the edge that enters DONE.
- done  output  1  one-cycle pulse; cube_out and ovf32 are valid from this cycle onward.
- cube_out  output  3*W  x^3, unsigned, exact (no truncation).
- ovf32  output  1  high when cube_out > 32'hFFFF_FFFF, i.e. the result does not fit a 32-bit radicand.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, cube_out=0, ovf32=0.
  - Internal x register, square register, accumulator and bit counter all cleared.
- Reset mid-operation aborts the operation. No done pulse is produced; operation resumes only after reset deasserts and a new start arrives.
- FSM states: IDLE, SQ, CU, DONE.
- IDLE:
  - start=1 → capture x_in into xr, clear acc and cnt, go to SQ, busy=1.
  - start=0 → remain in IDLE.
- SQ (exactly W cycles, cnt 0..W-1):
  - If xr[cnt]=1: acc += (xr zero-extended to 2W) << cnt.
  - At cnt=W-1: latch sq=acc (2W bits) in the same edge, clear acc and cnt, go to CU.
- CU (exactly W cycles, cnt 0..W-1):
  - If xr[cnt]=1: acc += (sq zero-extended to 3W) << cnt.
  - At cnt=W-1: go to DONE.
- DONE (1 cycle):
  - done=1, busy=0.
  - cube_out <= final acc; ovf32 <= |final acc[3W-1:32] (0 when 3W<=32).
  - Next state is IDLE.
- Latency: with the accept edge as edge 0, done is high during the cycle after edge 2W+1, i.e. 2W+1 edges later (23 for W=11). Throughput: one result per 2W+2 cycles.
- start while busy or in DONE is ignored. It is not queued and does not alter xr.
- x_in changes after acceptance have no effect.
- cube_out and ovf32 hold their value between done pulses and change only on the DONE edge.
- Arithmetic is unsigned and full-width; the accumulator is 3W bits and never wraps.
- Boundary operands x=0 and x=1 take the full latency, with no early exit.

Test Plan:
- Reset then x_in=5, start pulse → done exactly 23 cycles after the accept edge; cube_out=125, ovf32=0, busy high for 22 cycles.
- x_in=1625 → cube_out=4291015625, ovf32=0. Then x_in=1626 → cube_out=4298942376, ovf32=1.
- x_in=2047 (max) → cube_out=8577357823, ovf32=1. x_in=0 → cube_out=0 after the full latency.
- start held high continuously with x_in changing every cycle → each result matches the x_in value at its own accept edge; results spaced 24 cycles apart; no mid-run recapture.
- Assert reset at cycle 10 of a run with x_in=100 → outputs go to 0 immediately; no done pulse. A new start with x_in=3 then yields 27.
- Random 1000 operands in 0..2047 → cube_out equals the reference x^3; ovf32 matches x>1625; compared against the cube-root unit for round-trip identity.
